fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding instr_rom: owns the PC, drives the ROM byte address, registers the
//  returned 32-bit instruction into the IF/ID pipeline register. Handles sequential PC+4, branch/JAL
//  and JALR redirects from EX, stall from hazard unit, flush, and halts on misaligned/out-of-range fetch.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  ROM_BYTES  256            instr_rom size in bytes; fetch at pc > ROM_BYTES-4 is a fault
//  NOP_INSTR  32'h0000_0013  bubble instruction (addi x0,x0,0) inserted on flush/redirect/fault
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst             in   1   synchronous reset, active-low
//  stall           in   1   hold PC and IF/ID contents
//  flush           in   1   squash IF/ID (load bubble); PC still advances unless stall
//  redirect        in   1   EX-stage control transfer taken this cycle
//  redirect_kind   in   1   0 = branch/JAL (base+imm), 1 = JALR ((base+imm) & ~32'h1)
//  redirect_base   in   32  PC of transferring instr (kind 0) or rs1 value (kind 1)
//  redirect_imm    in   32  sign-extended immediate
//  rom_addr        out  32  byte address to instr_rom addr
//  rom_dout        in   32  instruction from instr_rom (combinational, same cycle)
//  if_id_valid     out  1   IF/ID holds a real instruction
//  if_id_instr     out  32  registered instruction
//  if_id_pc        out  32  PC of if_id_instr
//  if_id_pc_plus4  out  32  if_id_pc + 4
//  fault           out  1   sticky: fetch halted on bad target/address
// BEHAVIOUR
//  - rom_addr = pc (combinational). ROM read is combinational, so instr at pc appears in IF/ID 1 cycle later.
//  - Reset (rst==0 at edge): pc<=RESET_PC, if_id_valid<=0, if_id_instr<=NOP_INSTR, if_id_pc<=0,
//    if_id_pc_plus4<=0, fault<=0, state<=FETCH. Reset mid-redirect/stall discards all pending work.
//  - States: FETCH, FAULT. FAULT only left by reset.
//  - Priority per edge in FETCH: redirect > stall > normal; flush applied to IF/ID independently.
//  - Target = base+imm, 32-bit wrap-around modulo 2^32, no overflow flag; kind 1 clears bit0.
//  - redirect: if target[1:0]!=0 -> state<=FAULT, fault<=1, pc unchanged, IF/ID<=bubble. Else
//    pc<=target, IF/ID<=bubble (wrong-path instr squashed). redirect overrides stall.
//  - stall (no redirect): pc and all IF/ID outputs hold; flush with stall -> IF/ID<=bubble, pc holds.
//  - normal: pc<=pc+4; IF/ID<={valid=1, rom_dout, pc, pc+4}; flush -> bubble instead, pc still +4.
//  - Range check: pc > ROM_BYTES-4 while in FETCH (not stalled, no redirect) -> FAULT, IF/ID<=bubble.
//  - FAULT: pc frozen, if_id_valid=0, if_id_instr=NOP_INSTR, fault=1; all inputs ignored.
//  - bubble = {valid=0, instr=NOP_INSTR, pc/pc_plus4 hold previous}.
// STRUCTURE
//  - fetch_pkg: typedef enum logic {FETCH, FAULT} fetch_state_t; typedef enum logic {RD_BR, RD_JALR}
//    redirect_kind_t; localparam NOP_INSTR default value; typedef struct if_id_t {valid,instr,pc,pc_plus4}.
//  - Sub-module next_pc_gen (combinational): pc, redirect, kind, base, imm -> next_pc, misaligned.
//  - fetch_stage: PC register, FSM, IF/ID register, range check.
// TESTING
//  1 Reset, ROM words 0x00500093,0x00a00113 at 0,4; release -> cycle1 if_id_instr=0x00500093 pc=0,
//    cycle2 0x00a00113 pc=4, pc_plus4=8.
//  2 stall high 3 cycles at pc=8 -> rom_addr=8 and IF/ID unchanged 3 cycles; resume -> pc=0xC.
//  3 redirect kind0 base=0x10 imm=0xFFFFFFF8 -> pc=0x08, next if_id_valid=0 NOP_INSTR, then instr@8.
//  4 redirect kind1 base=0x21 imm=0x3 -> target 0x24 (bit0 cleared); base=0x20 imm=0x2 -> fault=1,
//    pc stays, valid=0 thereafter until rst low.
//  5 sequential run to pc=0xFC -> fetched ok; next pc=0x100 -> fault=1, if_id_valid=0.
//  6 redirect+stall same cycle -> redirect wins; flush+stall -> bubble, pc holds; rst low mid-stall ->
//    pc=RESET_PC, all outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM state, redirect kind and the IF/ID register layout.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef enum logic {
    RD_BR   = 1'b0,
    RD_JALR = 1'b1
  } redirect_kind_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC selection: sequential PC+4 or EX-stage redirect target with alignment check.
module next_pc_gen
  import fetch_pkg::*;
(
  input  logic [31:0]    pc_i,
  input  logic           redirect_i,
  input  redirect_kind_t kind_i,
  input  logic [31:0]    base_i,
  input  logic [31:0]    imm_i,
  output logic [31:0]    next_pc_o,
  output logic [31:0]    pc_plus4_o,
  output logic           misaligned_o
);

  logic [31:0] sum;
  logic [31:0] target;

  always_comb begin
    sum        = base_i + imm_i;
    target     = (kind_i == RD_JALR) ? (sum & ~32'h1) : sum;
    pc_plus4_o = pc_i + 32'd4;
    next_pc_o  = redirect_i ? target : pc_plus4_o;
    // JALR clears bit0 only, so a target ending in 2'b10 still faults here
    misaligned_o = redirect_i && (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, FETCH/FAULT FSM, ROM address drive and IF/ID pipeline register.
//   state | meaning
//   FETCH | fetching from rom_addr_o = pc each cycle
//   FAULT | halted on misaligned target or out-of-range PC; left only by reset
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 256,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic        redirect_kind_i,
  input  logic [31:0] redirect_base_i,
  input  logic [31:0] redirect_imm_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_dout_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic        fault_o
);

  localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  if_id_t       if_id_q, if_id_d;

  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;
  logic         misaligned;
  logic         out_of_range;
  if_id_t       bubble;

  next_pc_gen u_next_pc_gen (
    .pc_i         (pc_q),
    .redirect_i   (redirect_i),
    .kind_i       (redirect_kind_t'(redirect_kind_i)),
    .base_i       (redirect_base_i),
    .imm_i        (redirect_imm_i),
    .next_pc_o    (next_pc),
    .pc_plus4_o   (pc_plus4),
    .misaligned_o (misaligned)
  );

  assign out_of_range = (pc_q > LAST_PC);

  always_comb begin
    bubble   = '{valid: 1'b0, instr: NOP_INSTR, pc: if_id_q.pc, pc_plus4: if_id_q.pc_plus4};
    state_d  = state_q;
    pc_d     = pc_q;
    if_id_d  = if_id_q;

    case (state_q)
      FETCH: begin
        if (redirect_i) begin
          // wrong-path instruction at pc_q is squashed either way
          if_id_d = bubble;
          if (misaligned) begin
            state_d = FAULT;
          end else begin
            pc_d = next_pc;
          end
        end else if (stall_i) begin
          if (flush_i) begin
            if_id_d = bubble;
          end
        end else if (out_of_range) begin
          state_d = FAULT;
          if_id_d = bubble;
        end else begin
          pc_d = next_pc;
          if (flush_i) begin
            if_id_d = bubble;
          end else begin
            if_id_d = '{valid: 1'b1, instr: rom_dout_i, pc: pc_q, pc_plus4: pc_plus4};
          end
        end
      end
      FAULT: begin
        if_id_d = bubble;
      end
      default: begin
        state_d = FAULT;
        if_id_d = bubble;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      if_id_q <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign rom_addr_o       = pc_q;
  assign if_id_valid_o    = if_id_q.valid;
  assign if_id_instr_o    = if_id_q.instr;
  assign if_id_pc_o       = if_id_q.pc;
  assign if_id_pc_plus4_o = if_id_q.pc_plus4;
  assign fault_o          = (state_q == FAULT);

endmodule
